alu_exec_pipe: RTL and testbench
================================

// Module: alu_exec_pipe
// PURPOSE
//  Consumer end of the ALU control decode: takes aluOp/invA/invB/Cin/sign/rorSel
//  plus 16-bit operands from the ID/EX boundary and produces result and flags.
//  Two-stage elastic pipeline (S1 operand register, S2 result register).
//  valid/ready handshake on both sides, full throughput, synchronous flush.
//  Sits in the execute stage between decode/alu_cntrl and the EX/MEM boundary.
// PARAMETERS
//  WIDTH   16  datapath width; shift amount is b[$clog2(WIDTH)-1:0]
// PORTS
//  clk        in   1      single clock, all state on posedge
//  rst        in   1      synchronous, active-low reset
//  flush      in   1      sync kill of all in-flight ops (mispredict)
//  in_valid   in   1      upstream op present
//  in_ready   out  1      pipe can accept this cycle
//  a, b       in   WIDTH  operands
//  aluOp      in   3      operation select (encoding in package)
//  invA,invB  in   1      bitwise-invert operand before use
//  Cin        in   1      adder carry-in
//  sign       in   1      1: signed overflow rule; 0: unsigned
//  rorSel     in   1      with ROT op: 1 = rotate right, 0 = rotate left
//  out_valid  out  1      result present at S2
//  out_ready  in   1      downstream accepts
//  result     out  WIDTH  S2 result
//  cout,ofl,zero out 1    S2 flags
// BEHAVIOUR
//  - Reset (rst==0 at posedge): s1_valid=s2_valid=0; out_valid=0; result=0;
//    cout=ofl=zero=0; in_ready=1 the cycle after reset deasserts.
//  - Opcodes: 000 ADD, 001 AND, 010 OR, 011 XOR, 100 ROT, 101 SLL, 110 SRL,
//    111 PASSB. A'=invA?~a:a, B'=invB?~b:b applied to every op.
//  - ADD: {cout,sum}=A'+B'+Cin (WIDTH+1 bits). sign=1: ofl=(A'[msb]==B'[msb])
//    &&(sum[msb]!=A'[msb]); sign=0: ofl=cout. Non-ADD ops: cout=0, ofl=0.
//  - Shifts/rotates: amount=B'[3:0]; amount 0 returns A'; SRL zero-fills.
//  - zero = (result==0) for all ops.
//  - Handshake: transfer in when in_valid&&in_ready; out when out_valid&&out_ready.
//    s2_adv = !s2_valid || out_ready; in_ready = !s1_valid || s2_adv.
//    S1->S2 moves when s1_valid&&s2_adv. Latency 2 cycles accept->out_valid,
//    one op/cycle sustained with out_ready held high. No combinational path
//    from in_* to out_*; in_ready depends only on out_ready and state.
//  - Backpressure: out_ready low holds S2 stable (result/flags unchanged,
//    out_valid held); S1 fills, then in_ready drops. Inputs ignored when
//    in_ready=0 (no capture, no X propagation).
//  - Flush: both valid bits cleared next edge; a same-cycle in_valid is dropped
//    (in_ready still reported, nothing captured). Flush over reset: reset wins.
//  - Reset or flush mid-stall discards S1 and S2; data regs need not clear
//    except result/flags on reset.
// STRUCTURE
//  - Package alu_exec_pkg: ALU_ADD..ALU_PASSB localparams, WIDTH default,
//    flag bundle typedef {cout,ofl,zero}.
//  - One sub-module: alu_exec_core (combinational A'/B' conditioning, adder,
//    logic, barrel shift/rotate, flags) between S1 and S2; pipe control stays
//    in alu_exec_pipe.
// TESTING
//  1 ADD a=7FFF b=0001 sign=1 -> 2 cycles later result=8000 ofl=1 cout=0 zero=0.
//  2 SUB via invB=1 Cin=1, a=0005 b=0005 sign=0 -> result=0000 zero=1 cout=1 ofl=1.
//  3 ROT a=8001 b=0001 rorSel=1 -> C000; rorSel=0 -> 0003; SRL a=8000 b=000F -> 0001.
//  4 Stream 8 ADDs, out_ready=1 -> 8 results on 8 consecutive cycles, in order;
//    drop out_ready for 3 cycles mid-stream -> S2 held, in_ready low after 1 cycle,
//    no op lost or duplicated.
//  5 Two ops in flight, flush=1 with in_valid=1 -> next cycle out_valid=0,
//    s1 empty; following op emerges exactly 2 cycles after acceptance.
//  6 rst=0 during stall with out_valid=1 -> next cycle out_valid=0, result=0,
//    flags=0; in_ready=1 after rst returns high.

Source files
------------

// File: rtl/alu_exec_pkg.sv
// Shared definitions for the execute-stage ALU pipe.
//   ALU_* opcode constants, default datapath width, the control bundle that
//   travels with an op through S1, and the flag bundle held in S2.
package alu_exec_pkg;

  localparam int WIDTH_DEFAULT = 16;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_AND   = 3'b001;
  localparam logic [2:0] ALU_OR    = 3'b010;
  localparam logic [2:0] ALU_XOR   = 3'b011;
  localparam logic [2:0] ALU_ROT   = 3'b100;
  localparam logic [2:0] ALU_SLL   = 3'b101;
  localparam logic [2:0] ALU_SRL   = 3'b110;
  localparam logic [2:0] ALU_PASSB = 3'b111;

  typedef struct packed {
    logic [2:0] op;
    logic       inv_a;
    logic       inv_b;
    logic       cin;
    logic       sign;
    logic       ror_sel;
  } alu_ctrl_t;

  typedef struct packed {
    logic cout;
    logic ofl;
    logic zero;
  } alu_flags_t;

endpackage

// File: rtl/alu_exec_core.sv
// Combinational ALU between the S1 operand register and the S2 result register.
//   a, b    : raw operands from S1
//   ctrl    : opcode, operand inversion, carry-in, overflow rule, rotate direction
//   result  : ALU result
//   flags   : {cout, ofl, zero}; cout/ofl are only meaningful for ADD
module alu_exec_core
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_ctrl_t        ctrl,
  output logic [WIDTH-1:0] result,
  output alu_flags_t       flags
);

  localparam int              SHW     = $clog2(WIDTH);
  localparam logic [SHW:0]    WIDTH_V = (SHW + 1)'(WIDTH);

  logic [WIDTH-1:0] a_c;
  logic [WIDTH-1:0] b_c;
  logic [WIDTH:0]   sum;
  logic [SHW-1:0]   amt;
  logic [SHW:0]     amt_inv;

  always_comb begin
    a_c     = ctrl.inv_a ? ~a : a;
    b_c     = ctrl.inv_b ? ~b : b;
    sum     = {1'b0, a_c} + {1'b0, b_c} + {{WIDTH{1'b0}}, ctrl.cin};
    amt     = b_c[SHW-1:0];
    // For amount 0 the complementary shift is by WIDTH, which yields 0,
    // so rotates by zero fall out as a plain copy of A'.
    amt_inv = WIDTH_V - {1'b0, amt};

    result = '0;
    flags  = '0;
    case (ctrl.op)
      ALU_ADD: begin
        result     = sum[WIDTH-1:0];
        flags.cout = sum[WIDTH];
        flags.ofl  = ctrl.sign
                   ? ((a_c[WIDTH-1] == b_c[WIDTH-1]) && (sum[WIDTH-1] != a_c[WIDTH-1]))
                   : sum[WIDTH];
      end
      ALU_AND: result = a_c & b_c;
      ALU_OR:  result = a_c | b_c;
      ALU_XOR: result = a_c ^ b_c;
      ALU_ROT: result = ctrl.ror_sel ? ((a_c >> amt) | (a_c << amt_inv))
                                     : ((a_c << amt) | (a_c >> amt_inv));
      ALU_SLL: result = a_c << amt;
      ALU_SRL: result = a_c >> amt;
      default: result = b_c;  // ALU_PASSB
    endcase
    flags.zero = (result == '0);
  end

endmodule

// File: rtl/alu_exec_pipe.sv
// Two-stage elastic execute pipe: S1 holds operands, S2 holds result/flags.
//   clk, rst (sync, active-low), flush (sync kill of S1 and S2)
//   in_valid/in_ready + a, b, aluOp, invA, invB, Cin, sign, rorSel : upstream
//   out_valid/out_ready + result, cout, ofl, zero                   : downstream
// Handshake: a beat transfers on a side when valid && ready are both high at
// the posedge. in_ready depends only on out_ready and the stage valid bits,
// so there is no combinational path from in_* to out_*.
module alu_exec_pipe
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       aluOp,
  input  logic             invA,
  input  logic             invB,
  input  logic             Cin,
  input  logic             sign,
  input  logic             rorSel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ofl,
  output logic             zero
);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  alu_ctrl_t        s1_ctrl_q, s1_ctrl_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  alu_flags_t       flags_q, flags_d;

  logic             s2_adv;
  logic             accept;
  logic             s1_move;
  logic [WIDTH-1:0] core_result;
  alu_flags_t       core_flags;

  alu_exec_core #(.WIDTH(WIDTH)) u_core (
    .a      (s1_a_q),
    .b      (s1_b_q),
    .ctrl   (s1_ctrl_q),
    .result (core_result),
    .flags  (core_flags)
  );

  always_comb begin
    s2_adv   = !s2_valid_q || out_ready;
    in_ready = !s1_valid_q || s2_adv;
    // in_ready is still reported during flush, but nothing is captured.
    accept   = in_valid && in_ready && !flush;
    s1_move  = s1_valid_q && s2_adv;

    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_ctrl_d  = s1_ctrl_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_a_d     = a;
      s1_b_d     = b;
      s1_ctrl_d  = '{op: aluOp, inv_a: invA, inv_b: invB, cin: Cin,
                     sign: sign, ror_sel: rorSel};
    end else if (s1_move) begin
      s1_valid_d = 1'b0;
    end

    s2_valid_d = s2_valid_q;
    result_d   = result_q;
    flags_d    = flags_q;
    if (s2_adv) s2_valid_d = s1_valid_q;
    if (s1_move) begin
      result_d = core_result;
      flags_d  = core_flags;
    end

    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      flags_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      result_q   <= result_d;
      flags_q    <= flags_d;
    end
  end

  // Operand payload is qualified by s1_valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    s1_a_q    <= s1_a_d;
    s1_b_q    <= s1_b_d;
    s1_ctrl_q <= s1_ctrl_d;
  end

  assign out_valid = s2_valid_q;
  assign result    = result_q;
  assign cout      = flags_q.cout;
  assign ofl       = flags_q.ofl;
  assign zero      = flags_q.zero;

endmodule

// File: tb/tb_alu_exec_pipe.sv
module tb_alu_exec_pipe;
  import alu_exec_pkg::*;

  typedef logic [18:0] obs_t;  // {result[15:0], cout, ofl, zero}

  typedef struct {
    logic [15:0] a, b;
    logic [2:0]  op;
    logic        ia, ib, ci, sg, rr;
    logic [15:0] res;
    logic        c, o, z;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, result;
  logic [2:0]  aluOp;
  logic        invA, invB, Cin, sign, rorSel, cout, ofl, zero;

  always #5 clk = ~clk;

  alu_exec_pipe #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .aluOp(aluOp), .invA(invA), .invB(invB),
    .Cin(Cin), .sign(sign), .rorSel(rorSel),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .ofl(ofl), .zero(zero)
  );

  int   n_cmp = 0;
  int   n_fail = 0;
  int   spurious = 0;
  int   drain_timeouts = 0;
  obs_t exp_q[$];
  obs_t exp_done_q[$];
  obs_t act_q[$];
  vec_t vecs[8];

  // ---------------- reference model ----------------
  function automatic obs_t model(input logic [15:0] ra, rb, input logic [2:0] op,
                                 input logic ia, ib, ci, sg, rr);
    logic [15:0] ap, bp;
    int unsigned av, bv, r, n;
    int          sa, sb, ssum;
    logic        c, o;
    ap = ia ? ~ra : ra;
    bp = ib ? ~rb : rb;
    av = 32'(ap);
    bv = 32'(bp);
    n  = bv % 16;
    c  = 1'b0;
    o  = 1'b0;
    r  = 0;
    case (op)
      3'd0: begin
        r    = av + bv + 32'(ci);
        c    = (r >= 65536);
        sa   = $signed(ap);
        sb   = $signed(bp);
        ssum = sa + sb + int'(ci);
        o    = sg ? (ssum > 32767 || ssum < -32768) : c;
        r    = r % 65536;
      end
      3'd1: r = 32'(ap & bp);
      3'd2: r = 32'(ap | bp);
      3'd3: r = 32'(ap ^ bp);
      3'd4: begin
        r = av;
        repeat (n) r = rr ? ((r >> 1) | ((r & 1) << 15))
                          : (((r << 1) & 32'hFFFF) | (r >> 15));
      end
      3'd5: r = (av * (32'd1 << n)) % 65536;
      3'd6: r = av / (32'd1 << n);
      default: r = bv;
    endcase
    return {r[15:0], c, o, (r == 0)};
  endfunction

  // ---------------- scoreboard monitor ----------------
  // Sampled on the falling edge, where inputs and outputs are both stable
  // and reflect what the next rising edge will transfer.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) spurious++;
        else begin
          exp_done_q.push_back(exp_q.pop_front());
          act_q.push_back({result, cout, ofl, zero});
        end
      end
      if (flush) exp_q.delete();
      else if (in_valid && in_ready)
        exp_q.push_back(model(a, b, aluOp, invA, invB, Cin, sign, rorSel));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [15:0] ta, tb, input logic [2:0] top,
                        input logic tia, tib, tci, tsg, trr);
    a = ta; b = tb; aluOp = top;
    invA = tia; invB = tib; Cin = tci; sign = tsg; rorSel = trr;
    in_valid = 1'b1;
  endtask

  task automatic set_rand_op(input logic add_only);
    set_op(16'($urandom), 16'($urandom),
           add_only ? ALU_ADD : 3'($urandom_range(0, 7)),
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic drain();
    int g = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && g < 20) begin
      cyc();
      g++;
    end
    if (exp_q.size() != 0) drain_timeouts++;
    cyc();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (2) cyc();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (result !== 16'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 0000", result); end
    n_cmp++; if ({cout, ofl, zero} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {cout, ofl, zero}); end
    rst = 1'b1;
    cyc();
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_directed();
    vecs[0] = '{16'h7FFF, 16'h0001, ALU_ADD,   0, 0, 0, 1, 0, 16'h8000, 0, 1, 0};
    vecs[1] = '{16'h0005, 16'h0005, ALU_ADD,   0, 1, 1, 0, 0, 16'h0000, 1, 1, 1};
    vecs[2] = '{16'h8001, 16'h0001, ALU_ROT,   0, 0, 0, 0, 1, 16'hC000, 0, 0, 0};
    vecs[3] = '{16'h8001, 16'h0001, ALU_ROT,   0, 0, 0, 0, 0, 16'h0003, 0, 0, 0};
    vecs[4] = '{16'h8000, 16'h000F, ALU_SRL,   0, 0, 0, 0, 0, 16'h0001, 0, 0, 0};
    vecs[5] = '{16'h0001, 16'h0010, ALU_SLL,   0, 0, 0, 0, 0, 16'h0001, 0, 0, 0};
    vecs[6] = '{16'h1234, 16'hFFFF, ALU_PASSB, 0, 1, 1, 1, 0, 16'h0000, 0, 0, 1};
    vecs[7] = '{16'h5A5A, 16'hA5A5, ALU_XOR,   1, 0, 1, 1, 1, 16'h0000, 0, 0, 1};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].ia, vecs[i].ib,
             vecs[i].ci, vecs[i].sg, vecs[i].rr);
      cyc();
      in_valid = 1'b0;
      cyc();
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL dir%0d_out_valid: got %b expected 1", i, out_valid); end
      n_cmp++; if (result !== vecs[i].res) begin n_fail++; $display("FAIL dir%0d_result: got %h expected %h", i, result, vecs[i].res); end
      n_cmp++; if ({cout, ofl, zero} !== {vecs[i].c, vecs[i].o, vecs[i].z}) begin
        n_fail++; $display("FAIL dir%0d_flags: got %b expected %b", i, {cout, ofl, zero}, {vecs[i].c, vecs[i].o, vecs[i].z});
      end
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int run = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_rand_op(1'b1);
      cyc();
      if (i > 0 && out_valid) run++;
    end
    in_valid = 1'b0;
    cyc();
    if (out_valid) run++;
    n_cmp++; if (run !== 8) begin n_fail++; $display("FAIL b2b_valid_cycles: got %0d expected 8", run); end
    drain();
  endtask

  task automatic test_backpressure();
    int   sent = 0;
    int   ci = 0;
    logic acc;
    out_ready = 1'b1;
    set_rand_op(1'b0);
    while (sent < 10 && ci < 100) begin
      out_ready = !(ci >= 4 && ci <= 6);
      #1;
      if (ci >= 4 && ci <= 6) begin
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall%0d_in_ready: got %b expected 0", ci, in_ready); end
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall%0d_out_valid: got %b expected 1", ci, out_valid); end
        n_cmp++; if (exp_q.size() == 0 || {result, cout, ofl, zero} !== exp_q[0]) begin
          n_fail++; $display("FAIL stall%0d_hold: got %h expected %h", ci, {result, cout, ofl, zero}, (exp_q.size() != 0) ? exp_q[0] : 19'h0);
        end
      end
      acc = in_valid && in_ready;
      cyc();
      ci++;
      if (acc) begin
        sent++;
        if (sent < 10) set_rand_op(1'b0);
        else in_valid = 1'b0;
      end
    end
    drain();
  endtask

  task automatic test_flush();
    logic [15:0] da, db;
    logic [2:0]  dop;
    obs_t        dexp;
    out_ready = 1'b1;
    set_rand_op(1'b0); cyc();
    set_rand_op(1'b0); cyc();
    set_rand_op(1'b0);
    flush = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b expected 1", in_ready); end
    cyc();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b expected 0", out_valid); end
    cyc();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_s1_empty: got %b expected 0", out_valid); end
    da = 16'($urandom); db = 16'($urandom); dop = 3'($urandom_range(0, 7));
    dexp = model(da, db, dop, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    out_ready = 1'b1;
    set_op(da, db, dop, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_flush_lat1: got %b expected 0", out_valid); end
    cyc();
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL post_flush_lat2: got %b expected 1", out_valid); end
    n_cmp++; if ({result, cout, ofl, zero} !== dexp) begin n_fail++; $display("FAIL post_flush_data: got %h expected %h", {result, cout, ofl, zero}, dexp); end
    drain();
  endtask

  task automatic test_reset_stall();
    out_ready = 1'b0;
    set_rand_op(1'b0);
    cyc();
    in_valid = 1'b0;
    cyc();
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rstall_pre_valid: got %b expected 1", out_valid); end
    rst = 1'b0;
    cyc();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstall_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (result !== 16'h0) begin n_fail++; $display("FAIL rstall_result: got %h expected 0000", result); end
    n_cmp++; if ({cout, ofl, zero} !== 3'b000) begin n_fail++; $display("FAIL rstall_flags: got %b expected 000", {cout, ofl, zero}); end
    rst = 1'b1;
    cyc();
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstall_in_ready: got %b expected 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstall_after_valid: got %b expected 0", out_valid); end
    drain();
  endtask

  task automatic test_random();
    int   sent = 0;
    int   guard = 0;
    logic acc;
    set_rand_op(1'b0);
    while (sent < 150 && guard < 3000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc = in_valid && in_ready;
      cyc();
      guard++;
      if (acc) begin
        sent++;
        if (sent < 150) set_rand_op(1'b0);
        else in_valid = 1'b0;
      end
    end
    n_cmp++; if (sent !== 150) begin n_fail++; $display("FAIL random_sent: got %0d expected 150", sent); end
    drain();
  endtask

  task automatic test_scoreboard();
    obs_t e, g;
    n_cmp++; if (act_q.size() !== exp_done_q.size()) begin n_fail++; $display("FAIL sb_sizes: got %0d expected %0d", act_q.size(), exp_done_q.size()); end
    while (act_q.size() != 0 && exp_done_q.size() != 0) begin
      e = exp_done_q.pop_front();
      g = act_q.pop_front();
      n_cmp++; if (g !== e) begin n_fail++; $display("FAIL sb_result: got %h expected %h", g, e); end
    end
    n_cmp++; if (spurious !== 0) begin n_fail++; $display("FAIL sb_spurious: got %0d expected 0", spurious); end
    n_cmp++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL sb_lost: got %0d expected 0", exp_q.size()); end
    n_cmp++; if (drain_timeouts !== 0) begin n_fail++; $display("FAIL sb_drain_timeout: got %0d expected 0", drain_timeouts); end
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; aluOp = '0;
    invA = 1'b0; invB = 1'b0; Cin = 1'b0; sign = 1'b0; rorSel = 1'b0;
    #1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_stall();
    test_random();
    test_scoreboard();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
